// File: rtl/hpm_counter_unit_if.sv
// CSR-stage access port of the hardware performance-monitor unit.
// Master is the CSR stage; slave is hpm_counter_unit.
interface hpm_counter_unit_if #(
  parameter int XLEN = 64
);
  logic [1:0]      priv_i;
  logic            csr_re_i;
  logic            csr_we_i;
  logic [11:0]     csr_addr_i;
  logic [XLEN-1:0] csr_wdata_i;
  logic [XLEN-1:0] csr_rdata_o;
  logic            csr_rvalid_o;
  logic            csr_illegal_o;

  modport master (
    output priv_i,
    output csr_re_i,
    output csr_we_i,
    output csr_addr_i,
    output csr_wdata_i,
    input  csr_rdata_o,
    input  csr_rvalid_o,
    input  csr_illegal_o
  );

  modport slave (
    input  priv_i,
    input  csr_re_i,
    input  csr_we_i,
    input  csr_addr_i,
    input  csr_wdata_i,
    output csr_rdata_o,
    output csr_rvalid_o,
    output csr_illegal_o
  );
endinterface

// File: rtl/hpm_counter_unit.sv
// mcycle, minstret, mhpmcounter3+ with event selects, inhibit and counteren.
// Define HPM_OVERFLOW_IRQ_EN for overflow status (0x7C0), mask (0x7C1) and IRQ.
module hpm_counter_unit #(
  parameter int XLEN         = 64,
  parameter int NUM_COUNTERS = 14,
  parameter int NUM_EVENTS   = 16,
  parameter int SEL_W        = $clog2(NUM_EVENTS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  hpm_counter_unit_if.slave     csr,
  input  logic                  instret_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  output logic                  ovf_irq_o
);
  localparam int LAST = 2 + NUM_COUNTERS;
  localparam int EVW  = 2 ** SEL_W;

  function automatic logic [31:0] impl_mask();
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 32; k++)
      m[k] = (k == 0) || (k >= 2 && k <= LAST);
    return m;
  endfunction

  localparam logic [31:0] IMPL = impl_mask();

  logic [XLEN-1:0]  cnt [32];
  logic [SEL_W-1:0] sel [32];
  logic [31:0]      inhibit;
  logic [31:0]      counteren;
  logic [31:0]      inc;
  logic [EVW-1:0]   ev_pad;

  logic [11:0]     addr;
  logic [4:0]      idx;
  logic [31:0]     wd32;
  logic            is_m;
  logic            in_ctr;
  logic            in_shd;
  logic            in_evt;
  logic            is_inh;
  logic            is_cen;
  logic            legal;
  logic            wr;
  logic [XLEN-1:0] rd;

`ifdef HPM_OVERFLOW_IRQ_EN
  logic        is_ost;
  logic        is_oen;
  logic [31:0] ovf_st;
  logic [31:0] ovf_en;
  logic [31:0] ovf_set;
  logic [31:0] ovf_st_d;
  logic [31:0] ovf_en_d;

  assign is_ost = addr == 12'h7C0;
  assign is_oen = addr == 12'h7C1;
`endif

  assign addr   = csr.csr_addr_i;
  assign idx    = addr[4:0];
  assign wd32   = csr.csr_wdata_i[31:0];
  assign is_m   = csr.priv_i == 2'd3;
  assign in_ctr = addr[11:5] == 7'h58;
  assign in_shd = addr[11:5] == 7'h60;
  assign in_evt = addr[11:5] == 7'h19 && idx >= 5'd3;
  assign is_inh = addr == 12'h320;
  assign is_cen = addr == 12'h306;

  // Bit 0 and bits above NUM_EVENTS stay 0, so select 0 or out of range never hits
  assign ev_pad = EVW'({event_i, 1'b0});

  always_comb begin
    legal = 1'b0;
    rd    = '0;
    unique case (1'b1)
      in_ctr: begin
        legal = is_m;
        rd    = cnt[idx];
      end
      in_shd: begin
        legal = !csr.csr_we_i && idx != 5'd1
                && (is_m || counteren[idx]);
        rd    = cnt[idx];
      end
      in_evt: begin
        legal = is_m;
        rd    = XLEN'(sel[idx]);
      end
      is_inh: begin
        legal = is_m;
        rd    = XLEN'(inhibit);
      end
      is_cen: begin
        legal = is_m;
        rd    = XLEN'(counteren);
      end
`ifdef HPM_OVERFLOW_IRQ_EN
      is_ost: begin
        legal = is_m;
        rd    = XLEN'(ovf_st);
      end
      is_oen: begin
        legal = is_m;
        rd    = XLEN'(ovf_en);
      end
`endif
      default: ;
    endcase
  end

  assign wr = csr.csr_we_i && legal;

  always_comb begin
    inc    = '0;
    inc[0] = !inhibit[0];
    inc[2] = instret_i && !inhibit[2];
    for (int k = 3; k < 32; k++)
      inc[k] = IMPL[k] && !inhibit[k] && ev_pad[sel[k]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 32; k++) begin
        cnt[k] <= '0;
        sel[k] <= '0;
      end
      inhibit   <= '0;
      counteren <= '0;
    end else begin
      for (int k = 0; k < 32; k++) begin
        if (!IMPL[k])
          cnt[k] <= '0;
        else if (wr && in_ctr && idx == 5'(k))
          cnt[k] <= csr.csr_wdata_i;
        else if (inc[k])
          cnt[k] <= cnt[k] + XLEN'(1);
        if (k < 3 || !IMPL[k])
          sel[k] <= '0;
        else if (wr && in_evt && idx == 5'(k))
          sel[k] <= csr.csr_wdata_i[SEL_W-1:0];
      end
      if (wr && is_inh) inhibit <= wd32 & IMPL;
      if (wr && is_cen) counteren <= wd32 & IMPL;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csr.csr_rdata_o   <= '0;
      csr.csr_rvalid_o  <= 1'b0;
      csr.csr_illegal_o <= 1'b0;
    end else begin
      csr.csr_rvalid_o  <= csr.csr_re_i;
      csr.csr_illegal_o <= (csr.csr_re_i || csr.csr_we_i) && !legal;
      csr.csr_rdata_o   <= (csr.csr_re_i && legal) ? rd : '0;
    end
  end

`ifdef HPM_OVERFLOW_IRQ_EN
  always_comb begin
    ovf_set = '0;
    for (int k = 0; k < 32; k++)
      ovf_set[k] = inc[k] && (&cnt[k])
                   && !(wr && in_ctr && idx == 5'(k));
    ovf_st_d = (ovf_st & ~((wr && is_ost) ? wd32 : 32'd0))
               | ovf_set;
    ovf_en_d = (wr && is_oen) ? (wd32 & IMPL) : ovf_en;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_st    <= '0;
      ovf_en    <= '0;
      ovf_irq_o <= 1'b0;
    end else begin
      ovf_st    <= ovf_st_d;
      ovf_en    <= ovf_en_d;
      ovf_irq_o <= |(ovf_st_d & ovf_en_d);
    end
  end
`else
  assign ovf_irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_hpm_counter_unit.sv
// Scoreboard bench for hpm_counter_unit: directed plan items plus random traffic.
// Expected responses come from an address-level reference model of the counters.
module tb_hpm_counter_unit;
  localparam int XLEN = 64;
  localparam int NC   = 14;
  localparam int NE   = 16;
  localparam int SW   = $clog2(NE + 1);
  localparam bit [1:0] PM = 2'd3;
  localparam bit [1:0] PS = 2'd1;
  localparam bit [1:0] PU = 2'd0;

  typedef struct packed {
    logic        rv;
    logic        ill;
    logic [63:0] d;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          instret = 1'b0;
  logic [NE-1:0] ev = '0;
  logic          irq;

  hpm_counter_unit_if #(.XLEN(XLEN)) bus();

  hpm_counter_unit #(
    .XLEN(XLEN),
    .NUM_COUNTERS(NC),
    .NUM_EVENTS(NE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .csr(bus),
    .instret_i(instret),
    .event_i(ev),
    .ovf_irq_o(irq)
  );

  always #5 clk = ~clk;

  int        tests = 0;
  int        failed = 0;
  exp_t      q[$];
  bit [63:0] m_cnt [32];
  int        m_sel [32];
  bit [31:0] m_inh, m_cen, m_ost, m_oen;
  bit        exp_irq;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic bit impl(int k);
    return k == 0 || (k >= 2 && k <= 2 + NC);
  endfunction

  function automatic bit [31:0] mask();
    bit [31:0] m = '0;
    for (int k = 0; k < 32; k++) m[k] = impl(k);
    return m;
  endfunction

  function automatic bit legal(bit [1:0] p, bit we, int a);
    if (a == 'h306 || a == 'h320 || (a >= 'h323 && a <= 'h33F)
        || (a >= 'hB00 && a <= 'hB1F))
      return p == PM;
    if (a >= 'hC00 && a <= 'hC1F)
      return !we && a != 'hC01 && (p == PM || m_cen[a - 'hC00]);
`ifdef HPM_OVERFLOW_IRQ_EN
    if (a == 'h7C0 || a == 'h7C1) return p == PM;
`endif
    return 1'b0;
  endfunction

  function automatic bit [63:0] rdval(int a);
    if (a >= 'hB00 && a <= 'hB1F) return m_cnt[a - 'hB00];
    if (a >= 'hC00 && a <= 'hC1F) return m_cnt[a - 'hC00];
    if (a == 'h306) return 64'(m_cen);
    if (a == 'h320) return 64'(m_inh);
    if (a >= 'h323 && a <= 'h33F) return 64'(m_sel[a - 'h320]);
    if (a == 'h7C0) return 64'(m_ost);
    if (a == 'h7C1) return 64'(m_oen);
    return 64'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_cnt[i] = '0;
      m_sel[i] = 0;
    end
    m_inh = '0; m_cen = '0; m_ost = '0; m_oen = '0;
    exp_irq = 1'b0;
    q.delete();
  endtask

  // One clock of architectural behaviour: respond, count, then apply the write.
  task automatic model_tick(bit [1:0] p, bit re, bit we, int a,
                            bit [63:0] wd, bit [NE-1:0] e, bit ir);
    bit        ok = legal(p, we, a);
    bit [63:0] nxt [32];
    bit [31:0] wrap = '0;
    int        k;
    if (re) q.push_back({1'b1, !ok, ok ? rdval(a) : 64'd0});
    else if (we && !ok) q.push_back({1'b0, 1'b1, 64'd0});
    for (int i = 0; i < 32; i++) begin
      bit hit = 1'b0;
      if (i == 0) hit = !m_inh[0];
      else if (i == 2) hit = ir && !m_inh[2];
      else if (i >= 3 && impl(i) && !m_inh[i])
        if (m_sel[i] >= 1 && m_sel[i] <= NE) hit = e[m_sel[i] - 1];
      nxt[i] = m_cnt[i];
      if (hit) begin
        wrap[i] = m_cnt[i] == {64{1'b1}};
        nxt[i]  = m_cnt[i] + 64'd1;
      end
    end
    if (we && ok) begin
      if (a >= 'hB00 && a <= 'hB1F) begin
        k = a - 'hB00;
        if (impl(k)) begin
          nxt[k]  = wd;
          wrap[k] = 1'b0;
        end
      end else if (a == 'h306) m_cen = wd[31:0] & mask();
      else if (a == 'h320) m_inh = wd[31:0] & mask();
      else if (a >= 'h323 && a <= 'h33F) begin
        k = a - 'h320;
        if (impl(k)) m_sel[k] = int'(wd % (64'd1 << SW));
      end else if (a == 'h7C0) m_ost = m_ost & ~wd[31:0];
      else if (a == 'h7C1) m_oen = wd[31:0] & mask();
    end
    m_ost = m_ost | wrap;
    for (int i = 0; i < 32; i++) m_cnt[i] = nxt[i];
`ifdef HPM_OVERFLOW_IRQ_EN
    exp_irq = |(m_ost & m_oen);
`else
    exp_irq = 1'b0;
`endif
  endtask

  task automatic drive(bit [1:0] p, bit re, bit we, bit [11:0] a,
                       bit [63:0] wd, bit [NE-1:0] e, bit ir);
    bus.priv_i      = p;
    bus.csr_re_i    = re;
    bus.csr_we_i    = we;
    bus.csr_addr_i  = a;
    bus.csr_wdata_i = wd;
    ev              = e;
    instret         = ir;
    @(posedge clk);
    model_tick(p, re, we, int'(a), wd, e, ir);
    #1;
  endtask

  task automatic rd_csr(bit [1:0] p, bit [11:0] a);
    drive(p, 1'b1, 1'b0, a, 64'd0, '0, 1'b0);
  endtask

  task automatic wr_csr(bit [1:0] p, bit [11:0] a, bit [63:0] d);
    drive(p, 1'b0, 1'b1, a, d, '0, 1'b0);
  endtask

  task automatic idle(int n, bit [NE-1:0] e);
    repeat (n) drive(PM, 1'b0, 1'b0, 12'h000, 64'd0, e, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("ovf_irq", 64'(irq), 64'(exp_irq));
        if (bus.csr_rvalid_o || bus.csr_illegal_o) begin
          if (q.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL unexpected_resp: rvalid=%0b illegal=%0b, none expected",
                     bus.csr_rvalid_o, bus.csr_illegal_o);
          end else begin
            e = q.pop_front();
            chk("rvalid", 64'(bus.csr_rvalid_o), 64'(e.rv));
            chk("illegal", 64'(bus.csr_illegal_o), 64'(e.ill));
            chk("rdata", bus.csr_rdata_o, e.d);
          end
        end
      end
    end
  end

  initial begin : stim
    int        r;
    bit [1:0]  p;
    bit [11:0] a;
    bit [63:0] d;
    bus.priv_i = PM; bus.csr_re_i = 1'b0; bus.csr_we_i = 1'b0;
    bus.csr_addr_i = '0; bus.csr_wdata_i = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rdata", bus.csr_rdata_o, 64'd0);
    chk("reset_rvalid", 64'(bus.csr_rvalid_o), 64'd0);
    chk("reset_illegal", 64'(bus.csr_illegal_o), 64'd0);
    chk("reset_irq", 64'(irq), 64'd0);
    reset = 1'b0;
    idle(3, '0);
    rd_csr(PM, 12'hB00);
    idle(1, '0);

    // Reset asserted while a read is presented: that read never completes
    bus.csr_re_i = 1'b1; bus.csr_addr_i = 12'hB00;
    #2 reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk("midreset_rvalid", 64'(bus.csr_rvalid_o), 64'd0);
    @(negedge clk);
    bus.csr_re_i = 1'b0;
    reset = 1'b0;
    idle(3, '0);
    rd_csr(PM, 12'hB00);

    wr_csr(PM, 12'h323, 64'd5);
    wr_csr(PM, 12'h324, 64'd0);
    wr_csr(PM, 12'h325, 64'd17);
    wr_csr(PM, 12'h326, 64'hFFE3);
    idle(7, 16'h0010);
    idle(3, 16'hFFEF);
    rd_csr(PM, 12'hB03);
    rd_csr(PM, 12'hB04);
    rd_csr(PM, 12'hB05);
    rd_csr(PM, 12'h326);
    rd_csr(PM, 12'h325);

    wr_csr(PM, 12'h7C1, 64'h8);
    wr_csr(PM, 12'hB03, {64{1'b1}});
    idle(1, 16'h0010);
    rd_csr(PM, 12'hB03);
    rd_csr(PM, 12'h7C0);
    wr_csr(PM, 12'h7C0, 64'h8);
    idle(2, '0);
    rd_csr(PM, 12'h7C0);

    drive(PM, 1'b0, 1'b1, 12'hB03, 64'd100, 16'h0010, 1'b0);
    rd_csr(PM, 12'hB03);
    drive(PM, 1'b1, 1'b1, 12'hB03, 64'd55, 16'h0010, 1'b1);
    rd_csr(PM, 12'hB03);
    rd_csr(PM, 12'hB02);

    wr_csr(PM, 12'h306, 64'd0);
    rd_csr(PU, 12'hC00);
    wr_csr(PM, 12'h306, 64'd1);
    rd_csr(PU, 12'hC00);
    rd_csr(PS, 12'hC03);
    wr_csr(PM, 12'hC00, 64'd5);
    rd_csr(PM, 12'hB00);
    rd_csr(PM, 12'hC01);
    rd_csr(PU, 12'hB00);
    rd_csr(PM, 12'h321);

    wr_csr(PM, 12'h320, 64'h8);
    idle(4, 16'h0010);
    rd_csr(PM, 12'hB03);
    rd_csr(PM, 12'h320);
    wr_csr(PM, 12'h320, 64'h2);
    rd_csr(PM, 12'h320);
    rd_csr(PM, 12'hB1F);
    wr_csr(PM, 12'hB1F, 64'd9);
    rd_csr(PM, 12'hB1F);
    rd_csr(PM, 12'h33F);
    wr_csr(PM, 12'h320, 64'h0);

    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 3);
      p = (r == 0) ? PU : (r == 1) ? PS : PM;
      r = $urandom_range(0, 9);
      case (r)
        0: a = 12'hB00 + 12'($urandom_range(0, 31));
        1: a = 12'hC00 + 12'($urandom_range(0, 31));
        2: a = 12'h320 + 12'($urandom_range(0, 31));
        3: a = 12'h306;
        4: a = 12'h7C0 + 12'($urandom_range(0, 1));
        5: a = 12'($urandom);
        default: a = 12'hB03 + 12'($urandom_range(0, 3));
      endcase
      r = $urandom_range(0, 3);
      case (r)
        0: d = {$urandom, $urandom};
        1: d = {64{1'b1}} - 64'($urandom_range(0, 3));
        2: d = 64'($urandom_range(0, 31));
        default: d = 64'($urandom_range(0, 255));
      endcase
      drive(p, 1'($urandom), ($urandom_range(0, 3) == 0), a, d,
            NE'($urandom), 1'($urandom));
    end

    idle(3, '0);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
